// File: rtl/spi_responder.sv
// spi_responder: SPI mode-3 target holding a 32-bit register file written by 40-bit frames.
//
// Frame: 8-bit address/command (bit 39 = write, bits 38:32 = address) + 32-bit data, MSB first.
// The first 8 bits returned on MISO are status_in; the next 32 are the register addressed
// by the previous valid frame, so readback is pipelined by one frame.
//
// Ports:
//   clk_in, reset_in     system clock, asynchronous active-high reset
//   sck_in, cs_n_in,     SPI bus from the initiator, synchronized into clk_in
//   mosi_in
//   miso_out             serial data to the initiator
//   miso_oe_out          pad tri-state enable, high while selected
//   status_in            status byte sent as the first 8 MISO bits
//   regs_out             register file, reg k at [k*32+31:k*32]
//   frame_done_out       1-cycle pulse when a 40-bit frame is committed
//   frame_error_out      1-cycle pulse when a frame ends with a bit count other than 40
//   err_count_out        saturating error-frame counter, present only with
//                        SPI_RESPONDER_ERRCNT_EN defined; writing 0xA5A5A5A5 to
//                        address 0x7F clears it
module spi_responder #(
    parameter int NUM_REGS = 16,
    parameter int SYNC_LEN = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  sck_in,
    input  logic                  cs_n_in,
    input  logic                  mosi_in,
    output logic                  miso_out,
    output logic                  miso_oe_out,
    input  logic [7:0]            status_in,
    output logic [NUM_REGS*32-1:0] regs_out,
    output logic                  frame_done_out,
    output logic                  frame_error_out
`ifdef SPI_RESPONDER_ERRCNT_EN
    ,
    output logic [7:0]            err_count_out
`endif
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

    state_t                    state_q, state_d;
    // sck keeps one extra stage so the last two taps give edge detection
    logic [SYNC_LEN:0]         sck_q, sck_d;
    logic [SYNC_LEN-1:0]       cs_q, cs_d, mosi_q, mosi_d;
    // bit 39 goes straight to miso at select, so tx only holds the remaining 39 bits
    logic [38:0]               tx_q, tx_d;
    logic [39:0]               rx_q, rx_d;
    logic [5:0]                cnt_q, cnt_d;
    logic [6:0]                ptr_q, ptr_d;
    logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
    logic                      miso_q, miso_d;
    logic                      oe_q, oe_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
`ifdef SPI_RESPONDER_ERRCNT_EN
    logic [7:0]                ecnt_q, ecnt_d;
`endif

    logic        sck_rise, sck_fall, cs_s, mosi_s;
    logic [6:0]  addr;
    logic [31:0] rd_data;

    assign sck_rise = sck_q[SYNC_LEN-1] & ~sck_q[SYNC_LEN];
    assign sck_fall = ~sck_q[SYNC_LEN-1] & sck_q[SYNC_LEN];
    assign cs_s     = cs_q[SYNC_LEN-1];
    assign mosi_s   = mosi_q[SYNC_LEN-1];
    assign addr     = rx_q[38:32];

    // out-of-range read pointer matches no register and reads as zero
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (ptr_q == 7'(k)) rd_data = regs_q[k];
    end

    always_comb begin
        sck_d   = {sck_q[SYNC_LEN-1:0], sck_in};
        cs_d    = {cs_q[SYNC_LEN-2:0], cs_n_in};
        mosi_d  = {mosi_q[SYNC_LEN-2:0], mosi_in};
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        regs_d  = regs_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef SPI_RESPONDER_ERRCNT_EN
        ecnt_d  = ecnt_q;
`endif
        case (state_q)
            WAIT_IDLE: state_d = cs_s ? IDLE : WAIT_IDLE;
            IDLE: begin
                if (!cs_s) begin
                    tx_d    = {status_in[6:0], rd_data};
                    miso_d  = status_in[7];
                    oe_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    state_d = COMMIT;
                end else if (sck_rise) begin
                    rx_d  = {rx_q[38:0], mosi_s};
                    cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
                end else if (sck_fall && cnt_q != 6'd0) begin
                    // the leading fall precedes the first sample, so bit 39 stays put until then
                    miso_d = tx_q[38];
                    tx_d   = {tx_q[37:0], 1'b0};
                end
            end
            COMMIT: begin
                oe_d    = 1'b0;
                miso_d  = 1'b0;
                state_d = IDLE;
                if (cnt_q == 6'd40) begin
                    done_d = 1'b1;
                    ptr_d  = addr;
                    for (int k = 0; k < NUM_REGS; k++)
                        if (rx_q[39] && addr == 7'(k)) regs_d[k] = rx_q[31:0];
`ifdef SPI_RESPONDER_ERRCNT_EN
                    if (rx_q[39] && addr == 7'h7F && rx_q[31:0] == 32'hA5A5A5A5) ecnt_d = '0;
`endif
                end else begin
                    err_d = 1'b1;
`ifdef SPI_RESPONDER_ERRCNT_EN
                    ecnt_d = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
`endif
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= WAIT_IDLE;
            sck_q   <= '0;
            cs_q    <= '0;
            mosi_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            regs_q  <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SPI_RESPONDER_ERRCNT_EN
            ecnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            regs_q  <= regs_d;
            miso_q  <= miso_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef SPI_RESPONDER_ERRCNT_EN
            ecnt_q  <= ecnt_d;
`endif
        end
    end

    assign miso_out        = miso_q;
    assign miso_oe_out     = oe_q;
    assign regs_out        = regs_q;
    assign frame_done_out  = done_q;
    assign frame_error_out = err_q;
`ifdef SPI_RESPONDER_ERRCNT_EN
    assign err_count_out   = ecnt_q;
`endif

endmodule
